verbranch_arbiter: RTL and testbench
====================================

VERBRANCH_ARBITER -- requirements
Module: verbranch_arbiter

Interface
REQ-001 SHALL have parameter FAIR, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority to requester 0.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 SHALL have port req_ready  output  2  per-requester request accepted this cycle.
REQ-006 SHALL have port req_is_branch  input  2  per-requester decoded is_branch flag.
REQ-007 SHALL have port req_funct3  input  2x3  per-requester funct3 field.
REQ-008 SHALL have port req_a  input  2x32  per-requester operand a, word_t.
REQ-009 SHALL have port req_b  input  2x32  per-requester operand b, word_t.
REQ-010 SHALL have port rsp_valid  output  2  result valid for requester i.
REQ-011 SHALL have port rsp_taken  output  2  branch-taken result for requester i.
REQ-012 SHALL have port rsp_ready  input  2  requester i consumes its result.
REQ-013 SHALL have port taken_count  output  16  saturating count of taken results stored.

Function
REQ-014 SHALL evaluate one request per cycle with a single internal comparator: not is_branch gives 0; funct3 000 gives a==b; 001 gives a!=b; 100 gives signed a<b; 101 gives signed a>=b; 110 gives unsigned a<b; 111 gives unsigned a>=b; funct3 010 or 011 gives 0.
REQ-015 SHALL hold the result in a one-entry result register with fields full, owner (1 bit) and taken.
REQ-016 SHALL drive rsp_valid[i] = full and owner==i, and rsp_taken[i] = taken and owner==i.
REQ-017 SHALL compute free = not full, or full and rsp_ready[owner] (drain and refill in the same cycle).
REQ-018 SHALL grant at most one requester per cycle, and only when free is 1.
REQ-019 SHALL, with FAIR=1, track last_grant as 1 bit; when both requesters are valid, grant the one not equal to last_grant; when one is valid, grant that one.
REQ-020 SHALL update last_grant only on an accepted request.
REQ-021 SHALL, with FAIR=0, grant requester 0 whenever req_valid[0] is 1.
REQ-022 SHALL drive req_ready[i] = grant[i]; acceptance is req_valid[i] and req_ready[i].
REQ-023 SHALL keep req_ready independent of req_ready feedback, so it depends only on req_valid, rsp_ready and state.
REQ-024 SHALL give a latency of exactly 1 cycle from acceptance to rsp_valid.
REQ-025 SHALL, on accept, load full=1, owner=grant index and taken=comparator result at the next edge.
REQ-026 SHALL clear full when the result drains and there is no accept in that cycle.
REQ-027 SHALL hold the result register stable while full and rsp_ready[owner]=0 (backpressure).
REQ-028 SHALL ignore rsp_ready of the non-owner.
REQ-029 SHALL increment taken_count on each accept whose result is 1, and hold it at 16'hFFFF once reached.
REQ-030 SHALL ignore req_a, req_b, req_funct3 and req_is_branch of requesters without an accept.

Reset
REQ-031 SHALL, on reset assertion and independent of clk, set full=0, owner=0, taken=0, last_grant=1 (requester 0 wins the first tie) and taken_count=0.
REQ-032 SHALL drive rsp_valid=00, rsp_taken=00 and req_ready=00 while reset is high.
REQ-033 SHALL discard any in-flight result when reset is asserted mid-operation; it is never presented.
REQ-034 SHALL begin arbitration on the first rising clk edge after reset deasserts.

Verification
REQ-035 Single BLT: req0 a=FFFFFFFF, b=00000001, funct3=100, is_branch=1, rsp_ready=1 -> req_ready=01 in cycle 0; rsp_valid=01 and rsp_taken=01 in cycle 1; taken_count=1.
REQ-036 Unsigned versus signed: req1 same operands with funct3=110 -> rsp_taken[1]=0; with funct3=111 -> rsp_taken[1]=1.
REQ-037 Tie, FAIR=1: both requesters valid for 4 cycles with rsp_ready=11 -> grants 01,10,01,10; one result per cycle with no bubbles.
REQ-038 Backpressure: result owned by req0 with rsp_ready[0]=0 for 3 cycles and req1 valid -> req_ready=00 and rsp outputs stable; when rsp_ready[0]=1, req1 is accepted that same cycle and rsp_valid=10 in the next cycle.
REQ-039 Saturation and illegal funct3: 65537 accepted BEQ requests with a=b -> taken_count=FFFF; then funct3=010 -> rsp_taken=0 and the count stays FFFF.
REQ-040 Reset mid-operation: assert reset while full=1 with rsp_ready=0 -> rsp_valid=00 immediately, with no clock edge needed; after release, taken_count=0 and the first tie is granted to req0.

Source files
------------

// File: rtl/verbranch_arbiter.sv
// ---------------------------------------------------------------------------
// verbranch_arbiter
//
// Two requesters share one branch-condition evaluator. One request is
// accepted per cycle. Its outcome is held in a one-entry result register until
// the owning requester consumes it.
//
// Handshake rules (both directions):
//   A transfer happens on a rising clk edge when valid and ready are both 1.
//   req_ready is a one-hot grant. It depends only on req_valid, rsp_ready and
//   internal state, and never on the requester's own ready.
//   rsp_valid[i] stays high, with rsp_taken[i] stable, until rsp_ready[i] is
//   seen. rsp_ready of the requester that does not own the result is ignored.
//
// Parameters:
//   FAIR          1 = round-robin between requesters, 0 = requester 0 first
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   req_valid     [1:0]      request valid, bit i = requester i
//   req_ready     [1:0]      request accepted this cycle (one-hot grant)
//   req_is_branch [1:0]      decoded is_branch flag per requester
//   req_funct3    [1:0][2:0] funct3 per requester
//   req_a, req_b  [1:0][31:0] operands per requester
//   rsp_valid     [1:0]      result valid for requester i
//   rsp_taken     [1:0]      branch-taken result for requester i
//   rsp_ready     [1:0]      requester i consumes its result
//   taken_count   [15:0]     saturating count of taken results stored
// ---------------------------------------------------------------------------
module verbranch_arbiter #(
    parameter int FAIR = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_is_branch,
    input  logic [1:0][2:0]  req_funct3,
    input  logic [1:0][31:0] req_a,
    input  logic [1:0][31:0] req_b,
    output logic [1:0]       rsp_valid,
    output logic [1:0]       rsp_taken,
    input  logic [1:0]       rsp_ready,
    output logic [15:0]      taken_count
);

    // Result register and arbitration state.
    logic full;
    logic owner;
    logic taken;
    logic last_grant;

    logic        free;
    logic        grant_idx;
    logic [1:0]  grant;
    logic        accept;

    logic        sel_branch;
    logic [2:0]  sel_funct3;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        cmp_eq;
    logic        cmp_ltu;
    logic        cmp_lts;
    logic        cmp_taken;

    // The slot can take a new result if it is empty, or if it drains this
    // cycle. That allows one result per cycle with no bubbles.
    assign free = !full || rsp_ready[owner];

    // Pick the requester to grant. The index matters only when some request
    // is valid, because the grant below is gated by |req_valid.
    always_comb begin
        grant_idx = 1'b0;
        if (FAIR != 0) begin
            if (req_valid == 2'b11) begin
                grant_idx = ~last_grant;
            end else begin
                grant_idx = req_valid[1];
            end
        end else begin
            grant_idx = ~req_valid[0];
        end
    end

    // Grant is gated by reset, so req_ready reads 00 while reset is held,
    // even though the empty slot would otherwise look free.
    always_comb begin
        grant = 2'b00;
        if (!reset && free && (req_valid != 2'b00)) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;

    // Operands of the granted requester go to the one shared comparator.
    assign sel_branch = req_is_branch[grant_idx];
    assign sel_funct3 = req_funct3[grant_idx];
    assign sel_a      = req_a[grant_idx];
    assign sel_b      = req_b[grant_idx];

    // Signed less-than is built from the one unsigned magnitude compare.
    // If the signs differ, the negative operand (MSB set) is the smaller one.
    assign cmp_eq  = (sel_a == sel_b);
    assign cmp_ltu = (sel_a < sel_b);
    assign cmp_lts = (sel_a[31] != sel_b[31]) ? sel_a[31] : cmp_ltu;

    always_comb begin
        cmp_taken = 1'b0;
        if (sel_branch) begin
            case (sel_funct3)
                3'b000:  cmp_taken = cmp_eq;
                3'b001:  cmp_taken = !cmp_eq;
                3'b100:  cmp_taken = cmp_lts;
                3'b101:  cmp_taken = !cmp_lts;
                3'b110:  cmp_taken = cmp_ltu;
                3'b111:  cmp_taken = !cmp_ltu;
                default: cmp_taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full        <= 1'b0;
            owner       <= 1'b0;
            taken       <= 1'b0;
            last_grant  <= 1'b1;   // requester 0 wins the first tie
            taken_count <= 16'h0000;
        end else begin
            if (accept) begin
                full       <= 1'b1;
                owner      <= grant_idx;
                taken      <= cmp_taken;
                last_grant <= grant_idx;
                if (cmp_taken && (taken_count != 16'hFFFF)) begin
                    taken_count <= taken_count + 16'd1;
                end
            end else if (full && rsp_ready[owner]) begin
                // Clearing taken on drain means an empty slot never shows a
                // stale taken bit.
                full  <= 1'b0;
                taken <= 1'b0;
            end
        end
    end

    assign rsp_valid = {full && owner, full && !owner};
    assign rsp_taken = {taken && owner, taken && !owner};

endmodule

// File: tb/tb_verbranch_arbiter.sv
module tb_verbranch_arbiter;

  localparam int FAIR = 1;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_is_branch;
  logic [1:0][2:0]  req_funct3;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_taken;
  logic [1:0]       rsp_ready;
  logic [15:0]      taken_count;

  verbranch_arbiter #(.FAIR(FAIR)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_branch (req_is_branch),
    .req_funct3    (req_funct3),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_taken     (rsp_taken),
    .rsp_ready     (rsp_ready),
    .taken_count   (taken_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entry: bit 1 = owner, bit 0 = expected taken.
  logic [1:0] exp_q[$];
  logic       m_last;
  logic [15:0] m_count;
  logic [1:0] exp_t_in;   // expected comparator result per requester

  // Values sampled by the most recent step.
  logic [1:0]  s_ready;
  logic [1:0]  s_rv;
  logic [1:0]  s_rt;
  logic [15:0] s_count;

  typedef struct {
    logic        who;
    logic        br;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
  } vec_t;

  vec_t vecs[12];
  logic [1:0] tie_exp[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic branch_ref(input logic br, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] b);
    logic r;
    r = 1'b0;
    if (br) begin
      case (f3)
        3'b000:  r = (a == b);
        3'b001:  r = (a != b);
        3'b100:  r = ($signed(a) <  $signed(b));
        3'b101:  r = ($signed(a) >= $signed(b));
        3'b110:  r = (a <  b);
        3'b111:  r = (a >= b);
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int i, input logic br, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b);
    req_is_branch[i] = br;
    req_funct3[i]    = f3;
    req_a[i]         = a;
    req_b[i]         = b;
  endtask

  task automatic drive_random(input int i);
    logic [31:0] a;
    a = $urandom;
    drive_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
              ($urandom_range(0, 3) == 0) ? a : $urandom);
  endtask

  task automatic set_exp_from_ref();
    for (int i = 0; i < 2; i++) begin
      exp_t_in[i] = branch_ref(req_is_branch[i], req_funct3[i], req_a[i], req_b[i]);
    end
  endtask

  // One clock cycle. Inputs are already driven. Outputs are sampled and
  // compared at the falling edge. The reference model then advances as the
  // coming rising edge will, and the task returns 1 time unit after that edge.
  task automatic step();
    logic [1:0] exp_rv, exp_rt, exp_g;
    logic       free, idx;
    logic [1:0] head;
    @(negedge clk);
    exp_rv = 2'b00;
    exp_rt = 2'b00;
    free   = 1'b1;
    head   = 2'b00;
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      exp_rv[head[1]] = 1'b1;
      exp_rt[head[1]] = head[0];
      free = rsp_ready[head[1]];
    end
    exp_g = 2'b00;
    idx   = 1'b0;
    if (free && req_valid != 2'b00) begin
      if (req_valid == 2'b11) idx = ~m_last;
      else                    idx = req_valid[1];
      exp_g[idx] = 1'b1;
    end
    s_ready = req_ready;
    s_rv    = rsp_valid;
    s_rt    = rsp_taken;
    s_count = taken_count;
    check("req_ready",   {30'd0, req_ready}, {30'd0, exp_g});
    check("rsp_valid",   {30'd0, rsp_valid}, {30'd0, exp_rv});
    check("rsp_taken",   {30'd0, rsp_taken}, {30'd0, exp_rt});
    check("taken_count", {16'd0, taken_count}, {16'd0, m_count});
    if (exp_q.size() > 0 && free) void'(exp_q.pop_front());
    if (exp_g != 2'b00) begin
      exp_q.push_back({idx, exp_t_in[idx]});
      m_last = idx;
      if (exp_t_in[idx] && m_count != 16'hFFFF) m_count = m_count + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 2'b11;   // valid requests while in reset must not be granted
    rsp_ready = 2'b11;
    #1;
    check("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("reset_rsp_taken", {30'd0, rsp_taken}, 32'd0);
    check("reset_req_ready", {30'd0, req_ready}, 32'd0);
    exp_q.delete();
    m_last  = 1'b1;
    m_count = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", {16'd0, taken_count}, 32'd0);
    check("reset_req_ready_held", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b00;
    reset     = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{1'b0, 1'b1, 3'b100, 32'hFFFFFFFF, 32'h00000001, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 3'b110, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 3'b111, 32'hFFFFFFFF, 32'h00000001, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 3'b000, 32'h12345678, 32'h12345678, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h12345678, 32'h12345678, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 3'b101, 32'h80000000, 32'h7FFFFFFF, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 3'b100, 32'h80000000, 32'h7FFFFFFF, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 3'b000, 32'h00000005, 32'h00000005, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 3'b010, 32'h00000005, 32'h00000005, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3'b011, 32'h00000005, 32'h00000005, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'b110, 32'h00000000, 32'h00000000, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 3'b111, 32'h00000000, 32'h00000000, 1'b1};
    tie_exp[0] = 2'b01;
    tie_exp[1] = 2'b10;
    tie_exp[2] = 2'b01;
    tie_exp[3] = 2'b10;

    req_is_branch = '0;
    req_funct3    = '0;
    req_a         = '0;
    req_b         = '0;
    exp_t_in      = '0;
    do_reset();

    // Table: one requester at a time. The idle requester carries junk operands.
    rsp_ready = 2'b11;
    for (int k = 0; k < 12; k++) begin
      drive_random(!vecs[k].who);
      drive_req(vecs[k].who, vecs[k].br, vecs[k].f3, vecs[k].a, vecs[k].b);
      req_valid = 2'b00;
      req_valid[vecs[k].who] = 1'b1;
      exp_t_in = 2'b00;
      exp_t_in[vecs[k].who] = vecs[k].exp;
      step();
      if (k == 0) check("blt_first_grant", {30'd0, s_ready}, 32'd1);
      if (k == 1) check("blt_rsp_taken", {30'd0, s_rt}, 32'd1);
    end
    req_valid = 2'b00;
    step();
    check("table_drained_valid", {30'd0, s_rv}, 32'd2);

    // Tie with round-robin: grants alternate 01,10,01,10 and there are no bubbles.
    do_reset();
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      drive_random(0);
      drive_random(1);
      set_exp_from_ref();
      step();
      check("tie_grant", {30'd0, s_ready}, {30'd0, tie_exp[k]});
      if (k > 0) check("tie_no_bubble", {30'd0, s_rv}, {30'd0, tie_exp[k-1]});
    end

    // Backpressure: req0 holds the slot, req1 waits. rsp_ready of the non-owner is ignored.
    req_valid = 2'b01;
    drive_req(0, 1'b1, 3'b000, 32'hCAFE0000, 32'hCAFE0000);
    set_exp_from_ref();
    step();
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    drive_random(1);
    set_exp_from_ref();
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_stall_ready", {30'd0, s_ready}, 32'd0);
      check("bp_stall_valid", {30'd0, s_rv}, 32'd1);
      check("bp_stall_taken", {30'd0, s_rt}, 32'd1);
    end
    rsp_ready = 2'b01;
    step();
    check("bp_release_grant", {30'd0, s_ready}, 32'd2);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step();
    check("bp_release_valid", {30'd0, s_rv}, 32'd2);
    step();

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      drive_random(0);
      drive_random(1);
      set_exp_from_ref();
      step();
    end

    // Saturation: 65537 taken BEQs, then an illegal funct3.
    do_reset();
    rsp_ready = 2'b11;
    req_valid = 2'b01;
    drive_req(0, 1'b1, 3'b000, 32'h00000042, 32'h00000042);
    set_exp_from_ref();
    for (int k = 0; k < 65537; k++) step();
    drive_req(0, 1'b1, 3'b010, 32'h00000042, 32'h00000042);
    set_exp_from_ref();
    step();
    req_valid = 2'b00;
    step();
    check("sat_count", {16'd0, s_count}, 32'h0000FFFF);
    check("illegal_f3_valid", {30'd0, s_rv}, 32'd1);
    check("illegal_f3_taken", {30'd0, s_rt}, 32'd0);
    step();
    check("sat_count_hold", {16'd0, s_count}, 32'h0000FFFF);

    // Reset mid-operation: the held result disappears with no clock edge.
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    drive_req(0, 1'b1, 3'b000, 32'h1, 32'h1);
    set_exp_from_ref();
    step();
    req_valid = 2'b00;
    #2;
    check("midrst_before", {30'd0, rsp_valid}, 32'd1);
    do_reset();
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    drive_random(0);
    drive_random(1);
    set_exp_from_ref();
    step();
    check("midrst_first_tie", {30'd0, s_ready}, 32'd1);
    check("midrst_count", {16'd0, s_count}, 32'd0);
    req_valid = 2'b00;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
